dp_sequencer: RTL and testbench
===============================

// Module: dp_sequencer
// PURPOSE
//  Multi-cycle control FSM for the 16-bit stack/register datapath. Fetches a 20-bit word
//  {op[3:0], payload[15:0]} from instruction memory at the datapath PC over a req/ack
//  handshake, holds the payload on the datapath isr bus, and pulses that op's controls for one cycle.
//  Drives PC/SP write enables (pcw/spw); these connect to the specreg enables in the datapath.
// PARAMETERS
//  IW        20   instruction word width: op[IW-1:16] + 16-bit payload
//  CNTW      16   retired-instruction counter width
// PORTS
//  clk        in   1    clock; all state updates on posedge
//  reset      in   1    synchronous, active-high
//  run        in   1    level; IDLE->FETCH while high
//  imem_req   out  1    fetch request, address = datapath pcout
//  imem_ack   in   1    instruction valid on imem_data this cycle
//  imem_data  in   IW   fetched word
//  isr        out  16   payload to datapath (ALU funsel, reg sel, cc field, offset)
//  regw       out  1    register-bank write
//  memw       out  1    stack memory write at SP
//  memin      out  2    mem data sel: 0=reg x, 1=PC+1, 2=sign-ext payload
//  sflag      out  1    status flag update
//  spi        out  2    SP next: 0=hold, 1=+1, 2=-1
//  pcin       out  1    PC source: 0=memout (stack top), 1=incrementer
//  pci        out  1    incrementer: 0=PC+1, 1=PC+1+offset if cc true
//  pcw        out  1    PC register load enable
//  spw        out  1    SP register load enable
//  halted     out  1    sticky, set by HALT
//  illegal    out  1    sticky, set by undefined op
//  retired    out  CNTW instructions completed, wraps modulo 2^CNTW
// BEHAVIOUR
//  Reset: state=IDLE; IR=0; all outputs 0 (memin=0, spi=0), halted/illegal/retired=0.
//  Outside EXEC: regw=memw=sflag=pcw=spw=0, spi=0. Outside FETCH: imem_req=0.
//  isr = IR payload at all times.
//  States: IDLE -(run)-> FETCH; FETCH: imem_req=1; ack -> latch IR, -> EXEC; no ack -> stay.
//   EXEC: one cycle, controls per op, pcw=1, retired+1; -> FETCH if run, else IDLE.
//   HALT: all controls 0, halted=1; exits only on reset.
//  Min 2 cycles/instr (ack in first FETCH cycle). run dropping mid-FETCH: fetch completes, EXEC runs.
//  EXEC decode (op):  default pcin=1,pci=0 (PC+1), spw=0
//   0 NOP   : none
//   1 ALU   : regw=1, sflag=1
//   2 PUSH  : memw=1, memin=0, spi=2, spw=1
//   3 PUSHI : memw=1, memin=2, spi=2, spw=1
//   4 POP   : regw=1, spi=1, spw=1 (payload funsel selects y=mem[SP+1])
//   5 BR    : pci=1 (cc from payload[15:12])
//   6 CALL  : memw=1, memin=1, spi=2, spw=1, pci=1
//   7 RET   : pcin=0, spi=1, spw=1
//   8 HALT  : pcw=0, retired+1, -> HALT
//   9-15    : NOP behaviour, illegal=1 (sticky), execution continues
//  imem_ack outside FETCH ignored. Reset wins over every other event in the same cycle.
//  retired 2^CNTW-1 +1 -> 0, no flag.
// TESTING
//  reset, run=0 20 cycles -> imem_req=0, all controls 0, retired=0
//  run=1; ack delayed 3 cycles, op=1 payload 16'h1300 -> imem_req 4 cycles; 1 EXEC cycle regw=sflag=pcw=1, isr=16'h1300, retired=1
//  PUSHI 16'h0005 then POP -> EXEC1 memw=1,memin=2,spi=2,spw=1; EXEC2 regw=1,spi=1,memw=0
//  CALL then RET, ack same cycle -> 2 cycles/instr; CALL memin=1,pci=1; RET pcin=0,spi=1
//  op=12 then op=8 -> illegal=1 after first EXEC; halted=1, pcw=0, imem_req=0 thereafter; retired=2
//  reset asserted during FETCH with ack=1 -> IR not latched, next state IDLE, outputs 0

Source files
------------

// File: rtl/dp_sequencer.sv
// Multi-cycle control sequencer for the 16-bit stack/register datapath.
// It fetches {op, payload} over a req/ack handshake and then pulses that op's datapath controls for one cycle.
module dp_sequencer #(
    parameter int IW   = 20,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [IW-1:0]   imem_data,
    output logic [15:0]     isr,
    output logic            regw,
    output logic            memw,
    output logic [1:0]      memin,
    output logic            sflag,
    output logic [1:0]      spi,
    output logic            pcin,
    output logic            pci,
    output logic            pcw,
    output logic            spw,
    output logic            halted,
    output logic            illegal,
    output logic [CNTW-1:0] retired
);

    localparam int OPW = IW - 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   ir_reg, ir_next;
    logic            halted_reg, halted_next;
    logic            illegal_reg, illegal_next;
    logic [CNTW-1:0] retired_reg, retired_next;

    logic [OPW-1:0]  op;
    logic [15:0]     op_hot;
    logic            op_undefined;

    assign op = ir_reg[IW-1:16];

    // One-hot opcode decode; ops 9..15 are undefined and behave as NOP.
    for (genvar gi = 0; gi < 16; gi++) begin : g_op_decode
        assign op_hot[gi] = (op == OPW'(gi));
    end
    assign op_undefined = |op_hot[15:9];

    assign isr     = ir_reg[15:0];
    assign halted  = halted_reg;
    assign illegal = illegal_reg;
    assign retired = retired_reg;

    always_comb begin
        state_next   = state_reg;
        ir_next      = ir_reg;
        halted_next  = halted_reg;
        illegal_next = illegal_reg;
        retired_next = retired_reg;
        imem_req     = 1'b0;
        regw         = 1'b0;
        memw         = 1'b0;
        memin        = 2'd0;
        sflag        = 1'b0;
        spi          = 2'd0;
        pcin         = 1'b0;
        pci          = 1'b0;
        pcw          = 1'b0;
        spw          = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (run) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_next    = imem_data;
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                pcin         = 1'b1;
                pcw          = 1'b1;
                retired_next = retired_reg + CNTW'(1);
                state_next   = run ? S_FETCH : S_IDLE;
                if (op_hot[1]) begin
                    regw  = 1'b1;
                    sflag = 1'b1;
                end
                if (op_hot[2]) begin
                    memw = 1'b1;
                    spi  = 2'd2;
                    spw  = 1'b1;
                end
                if (op_hot[3]) begin
                    memw  = 1'b1;
                    memin = 2'd2;
                    spi   = 2'd2;
                    spw   = 1'b1;
                end
                if (op_hot[4]) begin
                    regw = 1'b1;
                    spi  = 2'd1;
                    spw  = 1'b1;
                end
                if (op_hot[5]) begin
                    pci = 1'b1;
                end
                // CALL pushes the return address (PC+1) while branching.
                if (op_hot[6]) begin
                    memw  = 1'b1;
                    memin = 2'd1;
                    spi   = 2'd2;
                    spw   = 1'b1;
                    pci   = 1'b1;
                end
                if (op_hot[7]) begin
                    pcin = 1'b0;
                    spi  = 2'd1;
                    spw  = 1'b1;
                end
                if (op_hot[8]) begin
                    pcw         = 1'b0;
                    halted_next = 1'b1;
                    state_next  = S_HALT;
                end
                if (op_undefined) begin
                    illegal_next = 1'b1;
                end
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            ir_reg      <= '0;
            halted_reg  <= 1'b0;
            illegal_reg <= 1'b0;
            retired_reg <= '0;
        end else begin
            state_reg   <= state_next;
            ir_reg      <= ir_next;
            halted_reg  <= halted_next;
            illegal_reg <= illegal_next;
            retired_reg <= retired_next;
        end
    end

endmodule

// File: tb/tb_dp_sequencer.sv
// Bench for dp_sequencer: directed scenarios plus random run/ack/reset traffic,
// checked every cycle against a phase-level model of the fetch/execute rules.
module tb_dp_sequencer;

    localparam int CNTW = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            run = 1'b0;
    logic            imem_ack = 1'b0;
    logic [19:0]     imem_data = '0;
    logic            imem_req;
    logic [15:0]     isr;
    logic            regw, memw, sflag, pcin, pci, pcw, spw, halted, illegal;
    logic [1:0]      memin, spi;
    logic [CNTW-1:0] retired;

    dp_sequencer #(.IW(20), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .run(run),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
        .isr(isr), .regw(regw), .memw(memw), .memin(memin), .sflag(sflag),
        .spi(spi), .pcin(pcin), .pci(pci), .pcw(pcw), .spw(spw),
        .halted(halted), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       regw;
        logic       memw;
        logic [1:0] memin;
        logic       sflag;
        logic [1:0] spi;
        logic       pcin;
        logic       pci;
        logic       pcw;
        logic       spw;
    } ctl_t;

    int checks = 0;
    int passes = 0;

    // Model phase: 0 idle, 1 waiting for an instruction, 2 executing, 3 halted.
    int              m_phase = 0;
    logic [19:0]     m_ir = '0;
    logic            m_halted = 1'b0;
    logic            m_illegal = 1'b0;
    logic [CNTW-1:0] m_retired = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic ctl_t exec_ctl(input logic [3:0] op);
        ctl_t c;
        c = '0;
        c.pcin = 1'b1;
        c.pcw  = 1'b1;
        case (op)
            4'd1: begin c.regw = 1; c.sflag = 1; end
            4'd2: begin c.memw = 1; c.memin = 0; c.spi = 2; c.spw = 1; end
            4'd3: begin c.memw = 1; c.memin = 2; c.spi = 2; c.spw = 1; end
            4'd4: begin c.regw = 1; c.spi = 1; c.spw = 1; end
            4'd5: c.pci = 1;
            4'd6: begin c.memw = 1; c.memin = 1; c.spi = 2; c.spw = 1; c.pci = 1; end
            4'd7: begin c.pcin = 0; c.spi = 1; c.spw = 1; end
            4'd8: c.pcw = 0;
            default: ;
        endcase
        return c;
    endfunction

    task automatic check_all();
        ctl_t e;
        e = (m_phase == 2) ? exec_ctl(m_ir[19:16]) : '0;
        chk("imem_req", imem_req, m_phase == 1);
        chk("isr", isr, m_ir[15:0]);
        chk("regw", regw, e.regw);
        chk("memw", memw, e.memw);
        chk("memin", memin, e.memin);
        chk("sflag", sflag, e.sflag);
        chk("spi", spi, e.spi);
        chk("pcin", pcin, e.pcin);
        chk("pci", pci, e.pci);
        chk("pcw", pcw, e.pcw);
        chk("spw", spw, e.spw);
        chk("halted", halted, m_halted);
        chk("illegal", illegal, m_illegal);
        chk("retired", retired, m_retired);
    endtask

    // Advance one clock: predict from the inputs presented, then compare after the edge.
    task automatic step();
        int              n_phase;
        logic [19:0]     n_ir;
        logic            n_halted, n_illegal;
        logic [CNTW-1:0] n_retired;
        n_phase = m_phase; n_ir = m_ir; n_halted = m_halted;
        n_illegal = m_illegal; n_retired = m_retired;
        if (reset) begin
            n_phase = 0; n_ir = '0; n_halted = 0; n_illegal = 0; n_retired = '0;
        end else if (m_phase == 0) begin
            if (run) n_phase = 1;
        end else if (m_phase == 1) begin
            if (imem_ack) begin n_ir = imem_data; n_phase = 2; end
        end else if (m_phase == 2) begin
            n_retired = m_retired + 1'b1;
            $display("exec op=%0d payload=%h retired=%0d", m_ir[19:16], m_ir[15:0], n_retired);
            if (m_ir[19:16] == 4'd8) begin
                n_halted = 1; n_phase = 3;
            end else begin
                if (m_ir[19:16] > 4'd8) n_illegal = 1;
                n_phase = run ? 1 : 0;
            end
        end
        @(posedge clk);
        #1;
        m_phase = n_phase; m_ir = n_ir; m_halted = n_halted;
        m_illegal = n_illegal; m_retired = n_retired;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1; run = 0; imem_ack = 0;
        step(); step();
        reset = 0;
    endtask

    initial begin
        int req_cycles;
        int r;

        // Reset, then idle with run low.
        do_reset();
        repeat (20) step();
        chk("idle_req", imem_req, 0);
        chk("idle_retired", retired, 0);
        chk("idle_regw", regw, 0);

        // ALU with ack held off three cycles.
        run = 1; step();
        req_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (imem_req) req_cycles++;
            imem_ack = (i == 3);
            imem_data = {4'd1, 16'h1300};
            step();
        end
        chk("alu_req_cycles", req_cycles, 4);
        chk("alu_regw", regw, 1);
        chk("alu_sflag", sflag, 1);
        chk("alu_pcw", pcw, 1);
        chk("alu_isr", isr, 16'h1300);
        imem_ack = 0; run = 0; step();
        chk("alu_retired", retired, 1);
        chk("model_retired", m_retired, 1);

        // PUSHI then POP.
        run = 1; step();
        imem_ack = 1; imem_data = {4'd3, 16'h0005}; step();
        chk("pushi_memw", memw, 1);
        chk("pushi_memin", memin, 2);
        chk("pushi_spi", spi, 2);
        chk("pushi_spw", spw, 1);
        imem_ack = 0; step();
        imem_ack = 1; imem_data = {4'd4, 16'h0021}; step();
        chk("pop_regw", regw, 1);
        chk("pop_spi", spi, 1);
        chk("pop_memw", memw, 0);

        // CALL then RET, ack held high: two cycles per instruction.
        imem_data = {4'd6, 16'h5004}; step();
        r = retired;
        step();
        chk("call_memin", memin, 1);
        chk("call_pci", pci, 1);
        imem_data = {4'd7, 16'h0000}; step(); step();
        chk("ret_pcin", pcin, 0);
        chk("ret_spi", spi, 1);
        step();
        chk("callret_retired", retired, CNTW'(r + 2));

        // Undefined op then HALT.
        do_reset();
        run = 1; step();
        imem_ack = 1; imem_data = {4'd12, 16'h0000}; step();
        imem_ack = 0; step();
        chk("illegal_set", illegal, 1);
        imem_ack = 1; imem_data = {4'd8, 16'h0000}; step();
        chk("halt_pcw", pcw, 0);
        step();
        chk("halted_set", halted, 1);
        repeat (5) begin
            step();
            chk("halt_req", imem_req, 0);
        end
        chk("halt_retired", retired, 2);

        // Reset during a FETCH that is being acknowledged.
        do_reset();
        run = 1; step();
        reset = 1; imem_ack = 1; imem_data = {4'd1, 16'hffff}; step();
        chk("rstfetch_isr", isr, 0);
        chk("rstfetch_req", imem_req, 0);
        chk("rstfetch_regw", regw, 0);
        reset = 0; run = 0; imem_ack = 0; step();
        chk("rstfetch_idle", imem_req, 0);

        // Retired counter wrap.
        do_reset();
        run = 1; imem_ack = 1; imem_data = {4'd0, 16'h0000}; step();
        for (int i = 0; i < 255; i++) begin step(); step(); end
        chk("wrap_255", retired, 255);
        step(); step();
        chk("wrap_0", retired, 0);
        for (int i = 0; i < 4; i++) begin step(); step(); end
        chk("wrap_4", retired, 4);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            reset = ($urandom_range(0, 199) == 0) || (m_phase == 3 && $urandom_range(0, 9) == 0);
            run = ($urandom_range(0, 9) != 0);
            imem_ack = $urandom_range(0, 1);
            r = $urandom_range(0, 99);
            if (r < 3) imem_data = {4'd8, 16'($urandom)};
            else if (r < 10) imem_data = {4'($urandom_range(9, 15)), 16'($urandom)};
            else imem_data = {4'($urandom_range(0, 7)), 16'($urandom)};
            step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
